// File: rtl/mult_exec_unit_pkg.sv
// Shared constants for the iterative multiply unit: instruction package field
// positions, default widths and FSM state encoding.
package mult_exec_unit_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int TAG_W_DEF = 6;
    localparam int ROB_W_DEF = 6;

    localparam int PKG_W     = 66;
    localparam int VALID_BIT = 65;
    localparam int TAG_MSB   = 64;
    localparam int TAG_LSB   = 59;
    localparam int ROB_MSB   = 58;
    localparam int ROB_LSB   = 53;
    localparam int SIGN_BIT  = 52;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mult_state_e;

endpackage

// File: rtl/mult_exec_unit_if.sv
// Issue-side / writeback-side signal bundle of the multiply unit.
// master = issue register + result consumers, slave = the multiply unit.
interface mult_exec_unit_if
    import mult_exec_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int TAG_W = TAG_W_DEF,
    parameter int ROB_W = ROB_W_DEF
);
    logic [PKG_W-1:0] mult_inst_pkg;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             flush;
    logic             mult_done;
    logic             res_valid;
    logic [WIDTH-1:0] res_lo;
    logic [WIDTH-1:0] res_hi;
    logic [TAG_W-1:0] res_tag;
    logic [ROB_W-1:0] res_rob;

    modport master (
        output mult_inst_pkg, op_a, op_b, flush,
        input  mult_done, res_valid, res_lo, res_hi, res_tag, res_rob
    );

    modport slave (
        input  mult_inst_pkg, op_a, op_b, flush,
        output mult_done, res_valid, res_lo, res_hi, res_tag, res_rob
    );
endinterface

// File: rtl/mult_exec_unit_dp.sv
// Radix-2 shift-add datapath: accumulator, multiplicand/multiplier shifters, step counter.
// One multiplier bit consumed per step; acc_nxt exposes the post-step accumulator.
module mult_shift_add_dp #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic [WIDTH-1:0]   mcand_in,
    input  logic [WIDTH-1:0]   mplier_in,
    output logic [2*WIDTH-1:0] acc_nxt,
    output logic               last
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    assign acc_nxt = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    assign last    = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (load) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, mcand_in};
            mplier_d = mplier_in;
            cnt_d    = '0;
        end else if (step) begin
            acc_d    = acc_nxt;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: rtl/mult_exec_unit.sv
// Iterative multiply unit: captures the held package in IDLE, WIDTH shift-add cycles, one DONE cycle.
// Latency WIDTH+1 to mult_done/res_valid; flush squashes any state and acks a valid held package.
module mult_exec_unit
    import mult_exec_unit_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int TAG_W = TAG_W_DEF,
    parameter int ROB_W = ROB_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    mult_exec_unit_if.slave  io
);
    mult_state_e        state_q, state_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [ROB_W-1:0]   rob_q, rob_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   res_lo_q, res_lo_d;
    logic [WIDTH-1:0]   res_hi_q, res_hi_d;
    logic [TAG_W-1:0]   res_tag_q, res_tag_d;
    logic [ROB_W-1:0]   res_rob_q, res_rob_d;

    logic               pkg_vld, pkg_sgn, pkg_unused;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] acc_nxt, prod;
    logic               accept, step, dp_last, done_load;

    assign pkg_vld    = io.mult_inst_pkg[VALID_BIT];
    assign pkg_sgn    = io.mult_inst_pkg[SIGN_BIT];
    assign pkg_unused = ^io.mult_inst_pkg[SIGN_BIT-1:0];

    // Magnitude of -2^(WIDTH-1) wraps to itself, which is correct read as unsigned.
    assign a_mag = (pkg_sgn && io.op_a[WIDTH-1]) ? -io.op_a : io.op_a;
    assign b_mag = (pkg_sgn && io.op_b[WIDTH-1]) ? -io.op_b : io.op_b;
    assign prod  = neg_q ? -acc_nxt : acc_nxt;

    mult_shift_add_dp #(.WIDTH(WIDTH)) u_dp (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .step      (step),
        .mcand_in  (a_mag),
        .mplier_in (b_mag),
        .acc_nxt   (acc_nxt),
        .last      (dp_last)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (pkg_vld && !io.flush) begin
                    accept  = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                step = !io.flush;
                if (dp_last) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (io.flush) state_d = ST_IDLE;
    end

    // Result registers load on the final BUSY edge so they are stable throughout DONE.
    assign done_load = (state_q == ST_BUSY) && dp_last && !io.flush;

    always_comb begin
        tag_d     = tag_q;
        rob_d     = rob_q;
        neg_d     = neg_q;
        res_lo_d  = res_lo_q;
        res_hi_d  = res_hi_q;
        res_tag_d = res_tag_q;
        res_rob_d = res_rob_q;
        if (accept) begin
            tag_d = TAG_W'(io.mult_inst_pkg[TAG_MSB:TAG_LSB]);
            rob_d = ROB_W'(io.mult_inst_pkg[ROB_MSB:ROB_LSB]);
            neg_d = pkg_sgn && (io.op_a[WIDTH-1] ^ io.op_b[WIDTH-1]);
        end
        if (done_load) begin
            res_lo_d  = prod[WIDTH-1:0];
            res_hi_d  = prod[2*WIDTH-1:WIDTH];
            res_tag_d = tag_q;
            res_rob_d = rob_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            tag_q     <= '0;
            rob_q     <= '0;
            neg_q     <= 1'b0;
            res_lo_q  <= '0;
            res_hi_q  <= '0;
            res_tag_q <= '0;
            res_rob_q <= '0;
        end else begin
            state_q   <= state_d;
            tag_q     <= tag_d;
            rob_q     <= rob_d;
            neg_q     <= neg_d;
            res_lo_q  <= res_lo_d;
            res_hi_q  <= res_hi_d;
            res_tag_q <= res_tag_d;
            res_rob_q <= res_rob_d;
        end
    end

    assign io.mult_done = io.flush ? pkg_vld : (state_q == ST_DONE);
    assign io.res_valid = (state_q == ST_DONE) && !io.flush;
    assign io.res_lo    = res_lo_q;
    assign io.res_hi    = res_hi_q;
    assign io.res_tag   = res_tag_q;
    assign io.res_rob   = res_rob_q;
endmodule

// File: tb/tb_mult_exec_unit.sv
// Directed bench for mult_exec_unit: latency, signed corners, back-to-back, flush and reset.
module tb_mult_exec_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mult_exec_unit_if #(.WIDTH(16), .TAG_W(6), .ROB_W(6)) io();

    mult_exec_unit #(.WIDTH(16), .TAG_W(6), .ROB_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io.slave)
    );

    task automatic issue(input logic v, input logic s, input logic [5:0] tag,
                         input logic [5:0] rob, input logic [15:0] a, input logic [15:0] b);
        logic [65:0] p;
        p = '0;
        p[65] = v;
        p[64:59] = tag;
        p[58:53] = rob;
        p[52] = s;
        p[40:0] = 41'h155_5555_5555;
        io.mult_inst_pkg = p;
        io.op_a = a;
        io.op_b = b;
    endtask

    // Returns cycles from issue (cycle 0) to mult_done, or -1 on timeout; leaves time at that negedge.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (io.mult_done === 1'b1) begin
                lat = c;
                return;
            end
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        io.flush = 1'b0;
        issue(1'b0, 1'b0, 6'h00, 6'h00, 16'h0, 16'h0);
        #12;
        total++;
        if ({io.mult_done, io.res_valid} !== 2'b00) begin
            bad++; $display("FAIL reset_flags: got %b want 00", {io.mult_done, io.res_valid});
        end
        total++;
        if ({io.res_hi, io.res_lo, io.res_tag, io.res_rob} !== 44'h0) begin
            bad++; $display("FAIL reset_result: got %h want 0", {io.res_hi, io.res_lo, io.res_tag, io.res_rob});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned_basic();
        int lat;
        next_cycle();
        issue(1'b1, 1'b0, 6'h0A, 6'h03, 16'd3, 16'd5);
        wait_done(lat);
        total++;
        if (lat !== 17) begin bad++; $display("FAIL basic_latency: got %0d want 17", lat); end
        total++;
        if (io.res_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1", io.res_valid); end
        total++;
        if ({io.res_hi, io.res_lo} !== 32'h0000_000F) begin
            bad++; $display("FAIL basic_product: got %h want 0000000f", {io.res_hi, io.res_lo});
        end
        total++;
        if ({io.res_tag, io.res_rob} !== {6'h0A, 6'h03}) begin
            bad++; $display("FAIL basic_tag_rob: got %h/%h want 0a/03", io.res_tag, io.res_rob);
        end
        next_cycle();
        issue(1'b0, 1'b0, 6'h00, 6'h00, 16'h0, 16'h0);
        @(negedge clk);
        total++;
        if ({io.mult_done, io.res_valid} !== 2'b00) begin
            bad++; $display("FAIL basic_one_cycle: got %b want 00", {io.mult_done, io.res_valid});
        end
        total++;
        if (io.res_lo !== 16'h000F) begin bad++; $display("FAIL basic_hold: got %h want 000f", io.res_lo); end
    endtask

    task automatic test_reset_mid_busy();
        int lat;
        int spurious;
        next_cycle();
        issue(1'b1, 1'b0, 6'h11, 6'h22, 16'd100, 16'd100);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({io.mult_done, io.res_valid, io.res_hi, io.res_lo, io.res_tag, io.res_rob} !== 46'h0) begin
            bad++; $display("FAIL reset_mid_busy: got %h want 0",
                            {io.mult_done, io.res_valid, io.res_hi, io.res_lo, io.res_tag, io.res_rob});
        end
        issue(1'b0, 1'b0, 6'h00, 6'h00, 16'h0, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (io.mult_done !== 1'b0 || io.res_valid !== 1'b0) spurious++;
        end
        total++;
        if (spurious !== 0) begin bad++; $display("FAIL idle_no_done: got %0d cycles want 0", spurious); end
        next_cycle();
        issue(1'b1, 1'b0, 6'h05, 6'h06, 16'd6, 16'd7);
        wait_done(lat);
        total++;
        if (lat !== 17 || {io.res_hi, io.res_lo} !== 32'd42) begin
            bad++; $display("FAIL after_reset_op: got lat=%0d prod=%h want lat=17 prod=0000002a",
                            lat, {io.res_hi, io.res_lo});
        end
        next_cycle();
        issue(1'b0, 1'b0, 6'h00, 6'h00, 16'h0, 16'h0);
    endtask

    task automatic test_signed_corners();
        logic [15:0] va [5];
        logic [15:0] vb [5];
        logic        vs [5];
        logic [31:0] vp [5];
        int lat;
        va = '{16'hFFFD, 16'h8000, 16'hFFFF, 16'h8000, 16'hFFF9};
        vb = '{16'h0005, 16'h8000, 16'hFFFF, 16'h0001, 16'hFFFA};
        vs = '{1'b1,     1'b1,     1'b0,     1'b1,     1'b1};
        vp = '{32'hFFFF_FFF1, 32'h4000_0000, 32'hFFFE_0001, 32'hFFFF_8000, 32'h0000_002A};
        for (int i = 0; i < 5; i++) begin
            next_cycle();
            issue(1'b1, vs[i], 6'(i + 20), 6'(i), va[i], vb[i]);
            wait_done(lat);
            total++;
            if (lat !== 17 || io.res_valid !== 1'b1 || {io.res_hi, io.res_lo} !== vp[i]) begin
                bad++; $display("FAIL corner_%0d: got lat=%0d vld=%b prod=%h want lat=17 vld=1 prod=%h",
                                i, lat, io.res_valid, {io.res_hi, io.res_lo}, vp[i]);
            end
            next_cycle();
            issue(1'b0, 1'b0, 6'h00, 6'h00, 16'h0, 16'h0);
        end
    endtask

    task automatic test_back_to_back();
        int lat1, lat2;
        next_cycle();
        issue(1'b1, 1'b0, 6'h01, 6'h01, 16'd7, 16'd9);
        wait_done(lat1);
        total++;
        if (lat1 !== 17 || {io.res_hi, io.res_lo} !== 32'd63) begin
            bad++; $display("FAIL b2b_first: got lat=%0d prod=%h want lat=17 prod=0000003f",
                            lat1, {io.res_hi, io.res_lo});
        end
        next_cycle();
        issue(1'b1, 1'b0, 6'h02, 6'h02, 16'd2, 16'd2);
        wait_done(lat2);
        total++;
        if (lat1 + 1 + lat2 !== 35) begin
            bad++; $display("FAIL b2b_second_cycle: got %0d want 35", lat1 + 1 + lat2);
        end
        total++;
        if ({io.res_hi, io.res_lo} !== 32'h0000_0004 || {io.res_tag, io.res_rob} !== {6'h02, 6'h02}) begin
            bad++; $display("FAIL b2b_second_result: got %h tag=%h want 00000004 tag=02",
                            {io.res_hi, io.res_lo}, io.res_tag);
        end
        next_cycle();
        issue(1'b0, 1'b0, 6'h00, 6'h00, 16'h0, 16'h0);
    endtask

    task automatic test_flush_busy();
        int lat;
        io.flush = 1'b1;
        @(negedge clk);
        total++;
        if (io.mult_done !== 1'b0) begin bad++; $display("FAIL flush_idle_empty: got %b want 0", io.mult_done); end
        next_cycle();
        io.flush = 1'b0;
        issue(1'b1, 1'b0, 6'h30, 6'h31, 16'd100, 16'd200);
        repeat (8) @(negedge clk);
        next_cycle();
        io.flush = 1'b1;
        @(negedge clk);
        total++;
        if ({io.mult_done, io.res_valid} !== 2'b10) begin
            bad++; $display("FAIL flush_busy_ack: got %b want 10", {io.mult_done, io.res_valid});
        end
        next_cycle();
        io.flush = 1'b0;
        issue(1'b1, 1'b0, 6'h32, 6'h33, 16'd11, 16'd13);
        wait_done(lat);
        total++;
        if (lat !== 17 || {io.res_hi, io.res_lo} !== 32'h0000_008F || io.res_tag !== 6'h32) begin
            bad++; $display("FAIL flush_busy_next: got lat=%0d prod=%h tag=%h want lat=17 prod=0000008f tag=32",
                            lat, {io.res_hi, io.res_lo}, io.res_tag);
        end
        next_cycle();
        issue(1'b0, 1'b0, 6'h00, 6'h00, 16'h0, 16'h0);
    endtask

    task automatic test_flush_done();
        int lat;
        next_cycle();
        issue(1'b1, 1'b0, 6'h3A, 6'h3B, 16'd4, 16'd4);
        repeat (17) @(negedge clk);
        next_cycle();
        io.flush = 1'b1;
        @(negedge clk);
        total++;
        if ({io.mult_done, io.res_valid} !== 2'b10) begin
            bad++; $display("FAIL flush_done: got %b want 10", {io.mult_done, io.res_valid});
        end
        next_cycle();
        io.flush = 1'b0;
        issue(1'b0, 1'b0, 6'h00, 6'h00, 16'h0, 16'h0);
        @(negedge clk);
        total++;
        if ({io.mult_done, io.res_valid} !== 2'b00) begin
            bad++; $display("FAIL flush_done_after: got %b want 00", {io.mult_done, io.res_valid});
        end
        next_cycle();
        issue(1'b1, 1'b0, 6'h0C, 6'h0D, 16'd5, 16'd6);
        wait_done(lat);
        total++;
        if (lat !== 17 || {io.res_hi, io.res_lo} !== 32'd30) begin
            bad++; $display("FAIL flush_done_idle: got lat=%0d prod=%h want lat=17 prod=0000001e",
                            lat, {io.res_hi, io.res_lo});
        end
        next_cycle();
        issue(1'b0, 1'b0, 6'h00, 6'h00, 16'h0, 16'h0);
    endtask

    initial begin
        test_reset();
        test_unsigned_basic();
        test_reset_mid_busy();
        test_signed_corners();
        test_back_to_back();
        test_flush_busy();
        test_flush_done();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
